pad_cfg_ctrl: RTL and testbench

PAD_CFG_CTRL -- requirements
Module: pad_cfg_ctrl

---
 rtl/pad_cfg_ctrl.sv | 149 ++++++++++++++
 tb/tb_pad_cfg_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_cfg_ctrl.sv
// Pad configuration controller: request/response access to per-pad shadow registers,
// with an atomic commit into the active registers that drive the pad controls.
module pad_cfg_ctrl #(
  parameter int NUM_INPUT_PADS = 13,
  parameter int NUM_BIDIR_PADS = 41,
  parameter bit RESET_IE       = 1'b1,
  parameter int ADDR_W         = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [7:0]                req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [7:0]                rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd,
  output logic                      cfg_pending
);

  localparam int         CtrlAddr   = NUM_BIDIR_PADS + NUM_INPUT_PADS;
  localparam logic [5:0] BidirReset = {2'b00, RESET_IE, 3'b000};

  logic [NUM_BIDIR_PADS-1:0][5:0] bidirShadow_q, bidirShadow_d;
  logic [NUM_BIDIR_PADS-1:0][5:0] bidirActive_q, bidirActive_d;
  logic [NUM_INPUT_PADS-1:0][1:0] inputShadow_q, inputShadow_d;
  logic [NUM_INPUT_PADS-1:0][1:0] inputActive_q, inputActive_d;
  logic       lock_q, lock_d;
  logic       pending_q, pending_d;
  logic       rspValid_q, rspValid_d;
  logic       rspErr_q, rspErr_d;
  logic [7:0] rspRdata_q, rspRdata_d;

  logic accept;
  logic isPad;
  logic isCtrl;
  logic badPull;
  int   addrIdx;
  logic unusedWdata;

  assign req_ready   = !rspValid_q || rsp_ready;
  assign accept      = req_valid && req_ready;
  assign rsp_valid   = rspValid_q;
  assign rsp_rdata   = rspRdata_q;
  assign rsp_err     = rspErr_q;
  assign cfg_pending = pending_q;
  assign unusedWdata = ^req_wdata[7:6];

  always_comb begin
    addrIdx       = int'(req_addr);
    isPad         = addrIdx < CtrlAddr;
    isCtrl        = addrIdx == CtrlAddr;
    badPull       = req_wdata[5:4] == 2'b11;
    bidirShadow_d = bidirShadow_q;
    bidirActive_d = bidirActive_q;
    inputShadow_d = inputShadow_q;
    inputActive_d = inputActive_q;
    lock_d        = lock_q;
    rspValid_d    = rspValid_q && !rsp_ready;
    rspRdata_d    = rspRdata_q;
    rspErr_d      = rspErr_q;

    if (accept) begin
      rspValid_d = 1'b1;
      rspRdata_d = '0;
      rspErr_d   = 1'b0;
      if (!isPad && !isCtrl) begin
        rspErr_d = 1'b1;
      end else if (!req_write) begin
        if (isCtrl) rspRdata_d = {5'b0, pending_q, lock_q, 1'b0};
        for (int i = 0; i < NUM_BIDIR_PADS; i++)
          if (addrIdx == i)
            rspRdata_d = {1'b0, bidirShadow_q[i] != bidirActive_q[i], bidirShadow_q[i]};
        for (int i = 0; i < NUM_INPUT_PADS; i++)
          if (addrIdx == NUM_BIDIR_PADS + i)
            rspRdata_d = {1'b0, inputShadow_q[i] != inputActive_q[i], inputShadow_q[i], 4'b0};
      end else if (isCtrl) begin
        // Once locked, clearing lock is silently ignored but a commit is rejected.
        if (lock_q && req_wdata[0]) begin
          rspErr_d = 1'b1;
        end else if (!lock_q) begin
          if (req_wdata[0]) begin
            bidirActive_d = bidirShadow_q;
            inputActive_d = inputShadow_q;
          end
          if (req_wdata[1]) lock_d = 1'b1;
        end
      end else if (lock_q || badPull) begin
        rspErr_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_BIDIR_PADS; i++)
          if (addrIdx == i) bidirShadow_d[i] = req_wdata[5:0];
        for (int i = 0; i < NUM_INPUT_PADS; i++)
          if (addrIdx == NUM_BIDIR_PADS + i) inputShadow_d[i] = req_wdata[5:4];
      end
    end

    pending_d = (bidirShadow_d != bidirActive_d) || (inputShadow_d != inputActive_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bidirShadow_q <= {NUM_BIDIR_PADS{BidirReset}};
      bidirActive_q <= {NUM_BIDIR_PADS{BidirReset}};
      inputShadow_q <= '0;
      inputActive_q <= '0;
      lock_q        <= 1'b0;
      pending_q     <= 1'b0;
      rspValid_q    <= 1'b0;
      rspRdata_q    <= '0;
      rspErr_q      <= 1'b0;
    end else begin
      bidirShadow_q <= bidirShadow_d;
      bidirActive_q <= bidirActive_d;
      inputShadow_q <= inputShadow_d;
      inputActive_q <= inputActive_d;
      lock_q        <= lock_d;
      pending_q     <= pending_d;
      rspValid_q    <= rspValid_d;
      rspRdata_q    <= rspRdata_d;
      rspErr_q      <= rspErr_d;
    end
  end

  for (genvar g = 0; g < NUM_BIDIR_PADS; g++) begin : gBidir
    assign bidir_oe[g] = bidirActive_q[g][0];
    assign bidir_cs[g] = bidirActive_q[g][1];
    assign bidir_sl[g] = bidirActive_q[g][2];
    assign bidir_ie[g] = bidirActive_q[g][3];
    assign bidir_pu[g] = bidirActive_q[g][4];
    assign bidir_pd[g] = bidirActive_q[g][5];
  end

  for (genvar g = 0; g < NUM_INPUT_PADS; g++) begin : gInput
    assign input_pu[g] = inputActive_q[g][0];
    assign input_pd[g] = inputActive_q[g][1];
  end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Bench for pad_cfg_ctrl: directed literal sequence, then randomized traffic,
// all cycles compared against a per-address register-file model.
module tb_pad_cfg_ctrl;
  localparam int NB   = 41;
  localparam int NI   = 13;
  localparam int AW   = 6;
  localparam int CTRL = NB + NI;
  localparam int NTOT = NB + NI;

  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, cfg_pending;
  logic [AW-1:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic [NB-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_pu, input_pd;

  int checks = 0;
  int failures = 0;

  logic [7:0] mShadow [NTOT];
  logic [7:0] mActive [NTOT];
  bit mLock, mPending, mRspValid, mErr, mArmed, mAcc;
  logic [7:0] mRdata;

  logic [7:0] rd;
  logic er;
  int addr;
  int r;

  pad_cfg_ctrl #(
    .NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB), .RESET_IE(1'b1), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
    .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
    .input_pu(input_pu), .input_pd(input_pd), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model keeps each pad as a masked byte in the same layout software sees.
  function automatic logic [7:0] padMask(input int a);
    return (a < NB) ? 8'h3F : 8'h30;
  endfunction

  function automatic bit anyPending();
    for (int a = 0; a < NTOT; a++)
      if (mShadow[a] !== mActive[a]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] padField(input int bitPos, input bit inputPads);
    logic [63:0] v;
    v = '0;
    if (inputPads) for (int j = 0; j < NI; j++) v[j] = mActive[NB + j][bitPos];
    else for (int i = 0; i < NB; i++) v[i] = mActive[i][bitPos];
    return v;
  endfunction

  task automatic modelReset();
    for (int a = 0; a < NTOT; a++) begin
      mShadow[a] = (a < NB) ? 8'h08 : 8'h00;
      mActive[a] = mShadow[a];
    end
    mLock = 1'b0; mPending = 1'b0; mRspValid = 1'b0; mRdata = 8'h00; mErr = 1'b0;
  endtask

  task automatic modelRequest(input bit w, input int a, input logic [7:0] d);
    mRspValid = 1'b1; mRdata = 8'h00; mErr = 1'b0;
    if (a > CTRL) mErr = 1'b1;
    else if (!w) begin
      if (a == CTRL) mRdata = {5'b0, mPending, mLock, 1'b0};
      else mRdata = mShadow[a] | ((mShadow[a] != mActive[a]) ? 8'h40 : 8'h00);
    end else if (a == CTRL) begin
      if (mLock && d[0]) mErr = 1'b1;
      else if (!mLock) begin
        if (d[0]) for (int k = 0; k < NTOT; k++) mActive[k] = mShadow[k];
        if (d[1]) mLock = 1'b1;
      end
    end else if (mLock || ((d & 8'h30) == 8'h30)) mErr = 1'b1;
    else mShadow[a] = d & padMask(a);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      modelReset();
      mArmed = 1'b1;
    end else if (mArmed) begin
      mAcc = req_valid && (!mRspValid || rsp_ready);
      if (mRspValid && rsp_ready) mRspValid = 1'b0;
      if (mAcc) modelRequest(req_write, int'(req_addr), req_wdata);
      mPending = anyPending();
    end
  end

  always @(negedge clk) begin
    if (mArmed) begin
      checkOutput("req_ready", req_ready, !mRspValid || rsp_ready);
      checkOutput("rsp_valid", rsp_valid, mRspValid);
      if (mRspValid) begin
        checkOutput("rsp_rdata", rsp_rdata, mRdata);
        checkOutput("rsp_err", rsp_err, mErr);
      end
      checkOutput("cfg_pending", cfg_pending, mPending);
      checkOutput("bidir_oe", bidir_oe, padField(0, 1'b0));
      checkOutput("bidir_cs", bidir_cs, padField(1, 1'b0));
      checkOutput("bidir_sl", bidir_sl, padField(2, 1'b0));
      checkOutput("bidir_ie", bidir_ie, padField(3, 1'b0));
      checkOutput("bidir_pu", bidir_pu, padField(4, 1'b0));
      checkOutput("bidir_pd", bidir_pd, padField(5, 1'b0));
      checkOutput("input_pu", input_pu, padField(4, 1'b1));
      checkOutput("input_pd", input_pd, padField(5, 1'b1));
    end
  end

  // Issues one request with rsp_ready held high; returns #1 after the accepting edge.
  task automatic applyStimulus(input bit w, input int a, input logic [7:0] d,
                               output logic [7:0] rdata, output logic err);
    req_valid = 1'b1; req_write = w; req_addr = AW'(a); req_wdata = d; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("req_accepted", rsp_valid, 1'b1);
    rdata = rsp_rdata;
    err = rsp_err;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_req_ready", req_ready, 1'b1);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 8'h00);
    checkOutput("reset_rsp_err", rsp_err, 1'b0);
    checkOutput("reset_ie", bidir_ie, {NB{1'b1}});
    checkOutput("reset_oe", bidir_oe, 64'h0);
    checkOutput("reset_input_pu", input_pu, 64'h0);
    checkOutput("reset_pending", cfg_pending, 1'b0);

    applyStimulus(1'b0, 0, 8'h00, rd, er);
    checkOutput("read0_data", rd, 8'h08);
    checkOutput("read0_err", er, 1'b0);

    applyStimulus(1'b1, 3, 8'h19, rd, er);
    checkOutput("wr3_err", er, 1'b0);
    checkOutput("wr3_oe_unchanged", bidir_oe, 64'h0);
    checkOutput("wr3_pu_unchanged", bidir_pu, 64'h0);
    checkOutput("wr3_pending", cfg_pending, 1'b1);
    applyStimulus(1'b0, 3, 8'h00, rd, er);
    checkOutput("read3_data", rd, 8'h59);

    applyStimulus(1'b1, CTRL, 8'h01, rd, er);
    checkOutput("commit_err", er, 1'b0);
    checkOutput("commit_oe", bidir_oe, 64'h8);
    checkOutput("commit_pu", bidir_pu, 64'h8);
    checkOutput("commit_ie", bidir_ie, {NB{1'b1}});
    checkOutput("commit_pending", cfg_pending, 1'b0);

    applyStimulus(1'b0, 0, 8'h00, rd, er);
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(3);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("hold_req_ready", req_ready, 1'b0);
      checkOutput("hold_rsp_valid", rsp_valid, 1'b1);
      checkOutput("hold_rsp_rdata", rsp_rdata, 8'h08);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("after_hold_valid", rsp_valid, 1'b1);
    checkOutput("after_hold_rdata", rsp_rdata, 8'h19);

    applyStimulus(1'b1, NB, 8'h30, rd, er);
    checkOutput("input_pupd_err", er, 1'b1);
    applyStimulus(1'b0, NB, 8'h00, rd, er);
    checkOutput("input_readback", rd, 8'h00);
    checkOutput("input_read_err", er, 1'b0);
    applyStimulus(1'b1, 63, 8'h01, rd, er);
    checkOutput("bad_addr_err", er, 1'b1);

    applyStimulus(1'b1, 5, 8'h11, rd, er);
    applyStimulus(1'b1, CTRL, 8'h03, rd, er);
    checkOutput("commit_lock_err", er, 1'b0);
    checkOutput("commit_lock_oe", bidir_oe, 64'h28);
    applyStimulus(1'b1, 7, 8'h01, rd, er);
    checkOutput("locked_wr_err", er, 1'b1);
    applyStimulus(1'b1, CTRL, 8'h01, rd, er);
    checkOutput("locked_commit_err", er, 1'b1);
    checkOutput("locked_oe", bidir_oe, 64'h28);
    applyStimulus(1'b1, CTRL, 8'h00, rd, er);
    checkOutput("unlock_ignored_err", er, 1'b0);
    applyStimulus(1'b0, CTRL, 8'h00, rd, er);
    checkOutput("ctrl_read_locked", rd, 8'h02);
    applyStimulus(1'b0, 7, 8'h00, rd, er);
    checkOutput("read7_unchanged", rd, 8'h08);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst2_oe", bidir_oe, 64'h0);
    checkOutput("rst2_pu", bidir_pu, 64'h0);
    checkOutput("rst2_ie", bidir_ie, {NB{1'b1}});
    checkOutput("rst2_rsp_valid", rsp_valid, 1'b0);
    applyStimulus(1'b0, CTRL, 8'h00, rd, er);
    checkOutput("rst2_ctrl", rd, 8'h00);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 99));
      if (r < 5) addr = int'($urandom_range(CTRL + 1, 63));
      else if (r < 20) addr = CTRL;
      else addr = int'($urandom_range(0, CTRL - 1));
      req_addr = AW'(addr);
      if (addr == CTRL)
        req_wdata = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(2, 3)) : 8'($urandom_range(0, 1));
      else
        req_wdata = 8'($urandom_range(0, 255));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
